// File: rtl/alu16_pkg.sv
// Shared constants for the 4-bit, sixteen-operation ALU: data width and opcodes.
package alu16_pkg;

  localparam int DATA_W = 4;

  // Arithmetic
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_INC  = 4'b0010;
  localparam logic [3:0] OP_DEC  = 4'b0011;
  // Bitwise logic (carry always cleared)
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XNOR = 4'b1010;
  // Shifts and rotates (carry holds the bit shifted out)
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_ROL  = 4'b1101;
  localparam logic [3:0] OP_ROR  = 4'b1110;
  // Multiply (carry flags a non-zero high nibble)
  localparam logic [3:0] OP_MUL  = 4'b1111;

endpackage

// File: rtl/alu16_core.sv
// Combinational heart of the ALU: produces the next result and carry from s, a, b.
module alu16_core
  import alu16_pkg::*;
(
  input  logic [3:0]        s,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] o_next,
  output logic              c_next
);

  // Widened intermediates so carry/borrow and the product's high nibble fall out directly.
  logic [DATA_W:0]     sum_ab;
  logic [DATA_W:0]     diff_ab;
  logic [DATA_W:0]     sum_inc;
  logic [2*DATA_W-1:0] prod_ab;

  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign diff_ab = {1'b0, a} - {1'b0, b};
  assign sum_inc = {1'b0, a} + 5'd1;
  assign prod_ab = {4'b0000, a} * {4'b0000, b};

  // Opcode decode: one arm per operation, unused encodings give zero.
  always_comb begin
    o_next = '0;
    c_next = 1'b0;
    case (s)
      OP_ADD: begin
        o_next = sum_ab[DATA_W-1:0];
        c_next = sum_ab[DATA_W];
      end
      OP_SUB: begin
        // Borrow shows up as the wrapped ninth... fifth bit of the widened difference.
        o_next = diff_ab[DATA_W-1:0];
        c_next = diff_ab[DATA_W];
      end
      OP_INC: begin
        o_next = sum_inc[DATA_W-1:0];
        c_next = sum_inc[DATA_W];
      end
      OP_DEC: begin
        o_next = a - 4'd1;
        c_next = (a == 4'd0);
      end
      OP_AND:  o_next = a & b;
      OP_OR:   o_next = a | b;
      OP_XOR:  o_next = a ^ b;
      OP_NOT:  o_next = ~a;
      OP_NAND: o_next = ~(a & b);
      OP_NOR:  o_next = ~(a | b);
      OP_XNOR: o_next = ~(a ^ b);
      OP_SHL: begin
        o_next = {a[2:0], 1'b0};
        c_next = a[3];
      end
      OP_SHR: begin
        o_next = {1'b0, a[3:1]};
        c_next = a[0];
      end
      OP_ROL: begin
        o_next = {a[2:0], a[3]};
        c_next = a[3];
      end
      OP_ROR: begin
        o_next = {a[0], a[3:1]};
        c_next = a[0];
      end
      OP_MUL: begin
        o_next = prod_ab[DATA_W-1:0];
        c_next = (prod_ab[2*DATA_W-1:DATA_W] != 4'd0);
      end
      default: begin
        o_next = '0;
        c_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu16.sv
// 4-bit ALU top: one register stage holding result, carry and zero flag.
// Interface contract: no handshake. A new opcode/operand set is sampled on every
// rising clk edge and its result is visible from that edge until the next one.
module alu16
  import alu16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        s,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] o,
  output logic              c,
  output logic              z
);

  logic [DATA_W-1:0] o_next;
  logic              c_next;

  alu16_core u_core (
    .s      (s),
    .a      (a),
    .b      (b),
    .o_next (o_next),
    .c_next (c_next)
  );

  // Output registers; reset wins over the operation presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      o <= '0;
      c <= 1'b0;
      z <= 1'b1;
    end else begin
      o <= o_next;
      c <= c_next;
      z <= (o_next == '0);
    end
  end

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed sweeps, boundaries, reset cases, random traffic.
module tb_alu16;
  import alu16_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] s;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] o;
  logic       c;
  logic       z;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: packed {z, c, o} expected after the next edge.
  logic [5:0] exp_q[$];

  alu16 dut (
    .clk (clk),
    .rst (rst),
    .s   (s),
    .a   (a),
    .b   (b),
    .o   (o),
    .c   (c),
    .z   (z)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Plain integer arithmetic from the operation table; returns {z, c, o}.
  function automatic logic [5:0] ref_model(input int op, input int x, input int y);
    int r;
    int cv;
    int p;
    logic [5:0] ret;
    r  = 0;
    cv = 0;
    case (op)
      0:  begin p = x + y; r = p % 16; cv = (p >= 16); end
      1:  begin r = (x - y + 16) % 16; cv = (x < y); end
      2:  begin r = (x + 1) % 16; cv = (x == 15); end
      3:  begin r = (x + 15) % 16; cv = (x == 0); end
      4:  r = x & y;
      5:  r = x | y;
      6:  r = x ^ y;
      7:  r = 15 - x;
      8:  r = 15 - (x & y);
      9:  r = 15 - (x | y);
      10: r = 15 - (x ^ y);
      11: begin r = (x * 2) % 16; cv = x / 8; end
      12: begin r = x / 2; cv = x % 2; end
      13: begin r = (x * 2) % 16 + x / 8; cv = x / 8; end
      14: begin r = x / 2 + (x % 2) * 8; cv = x % 2; end
      default: begin p = x * y; r = p % 16; cv = (p >= 16); end
    endcase
    ret[3:0] = r[3:0];
    ret[4]   = (cv != 0);
    ret[5]   = (r == 0);
    return ret;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got o=%b c=%b z=%b, expected o=%b c=%b z=%b",
               tag, got[3:0], got[4], got[5], exp[3:0], exp[4], exp[5]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one cycle of inputs at the falling edge, then check just after the rising edge.
  task automatic issue(input string tag, input logic r, input logic [3:0] op,
                       input logic [3:0] x, input logic [3:0] y);
    logic [5:0] e;
    @(negedge clk);
    rst = r;
    s   = op;
    a   = x;
    b   = y;
    exp_q.push_back(r ? 6'b10_0000 : ref_model(int'(op), int'(x), int'(y)));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, {z, c, o}, e);
  endtask

  // Directed check with a hand-written expected value.
  task automatic issue_exp(input string tag, input logic [3:0] op, input logic [3:0] x,
                           input logic [3:0] y, input logic [5:0] e);
    @(negedge clk);
    rst = 1'b0;
    s   = op;
    a   = x;
    b   = y;
    @(posedge clk);
    #1;
    check(tag, {z, c, o}, e);
  endtask

  // Expected results for the a=0101, b=0110 sweep, as {z, c, o}.
  logic [5:0] sweep_exp [16] = '{
    6'b0_0_1011, 6'b0_1_1111, 6'b0_0_0110, 6'b0_0_0100,
    6'b0_0_0100, 6'b0_0_0111, 6'b0_0_0011, 6'b0_0_1010,
    6'b0_0_1011, 6'b0_0_1000, 6'b0_0_1100,
    6'b0_0_1010, 6'b0_1_0010, 6'b0_0_1010, 6'b0_1_1010,
    6'b0_1_1110
  };

  logic [5:0] held;

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    s   = OP_ADD;
    a   = 4'd5;
    b   = 4'd6;

    // Reset held two cycles with ADD 5+6 presented; release gives 1011.
    issue("reset_cycle1", 1'b1, OP_ADD, 4'd5, 4'd6);
    issue("reset_cycle2", 1'b1, OP_ADD, 4'd5, 4'd6);
    issue_exp("after_release", OP_ADD, 4'd5, 4'd6, 6'b0_0_1011);

    // Full opcode sweep.
    for (int i = 0; i < 16; i++) begin
      issue_exp($sformatf("sweep_op%0d", i), 4'(i), 4'b0101, 4'b0110, sweep_exp[i]);
    end

    // Carry / zero boundaries.
    issue_exp("add_wrap",  OP_ADD, 4'b1111, 4'b0001, 6'b1_1_0000);
    issue_exp("inc_wrap",  OP_INC, 4'b1111, 4'b0000, 6'b1_1_0000);
    issue_exp("dec_wrap",  OP_DEC, 4'b0000, 4'b0000, 6'b0_1_1111);
    issue_exp("sub_equal", OP_SUB, 4'b1001, 4'b1001, 6'b1_0_0000);
    issue_exp("mul_15x15", OP_MUL, 4'b1111, 4'b1111, 6'b0_1_0001);

    // Inputs changing between edges must not reach the outputs.
    issue_exp("hold_base", OP_XOR, 4'b1100, 4'b1010, 6'b0_0_0110);
    held = {z, c, o};
    @(negedge clk);
    s = OP_MUL;
    a = 4'b1111;
    b = 4'b1111;
    #2;
    check("no_comb_path", {z, c, o}, 6'b0_0_0110);

    // Mid-stream reset discards the MUL presented with it.
    issue_exp("mid_add", OP_ADD, 4'd3, 4'd4, 6'b0_0_0111);
    issue("mid_reset", 1'b1, OP_MUL, 4'd7, 4'd3);
    issue_exp("after_mid_reset", OP_OR, 4'b0000, 4'b0000, 6'b1_0_0000);

    // Random traffic with occasional reset cycles.
    for (int i = 0; i < 1000; i++) begin
      issue("random", ($urandom_range(0, 31) == 0), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
